// File: rtl/adbg_tap_pkg.sv
// adbg_tap shared definitions: TAP state encoding, opcodes, IR capture
// pattern and the instruction-to-data-register decode.
// Optional feature macro: ADBG_TAP_IDCODE_EN (IDCODE register and opcode).
package adbg_tap_pkg;

    typedef enum logic [3:0] {
        ST_TEST_LOGIC_RESET = 4'd0,
        ST_RUN_TEST_IDLE    = 4'd1,
        ST_SELECT_DR        = 4'd2,
        ST_CAPTURE_DR       = 4'd3,
        ST_SHIFT_DR         = 4'd4,
        ST_EXIT1_DR         = 4'd5,
        ST_PAUSE_DR         = 4'd6,
        ST_EXIT2_DR         = 4'd7,
        ST_UPDATE_DR        = 4'd8,
        ST_SELECT_IR        = 4'd9,
        ST_CAPTURE_IR       = 4'd10,
        ST_SHIFT_IR         = 4'd11,
        ST_EXIT1_IR         = 4'd12,
        ST_PAUSE_IR         = 4'd13,
        ST_EXIT2_IR         = 4'd14,
        ST_UPDATE_IR        = 4'd15
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_DEBUG  = 2'd2
    } dr_sel_e;

    localparam logic [3:0] OP_IDCODE  = 4'b0010;
    localparam logic [3:0] OP_DEBUG   = 4'b1000;
    localparam logic [3:0] OP_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    // Map a latched opcode onto the data register it selects; anything
    // unrecognised falls back to the 1-bit bypass register.
    function automatic dr_sel_e decode_dr(input logic [3:0] op);
        dr_sel_e sel;
        case (op)
            OP_DEBUG:  sel = DR_DEBUG;
`ifdef ADBG_TAP_IDCODE_EN
            OP_IDCODE: sel = DR_IDCODE;
`else
            OP_IDCODE: sel = DR_BYPASS;
`endif
            OP_BYPASS: sel = DR_BYPASS;
            default:   sel = DR_BYPASS;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/adbg_tap_fsm.sv
// adbg_tap_fsm: IEEE 1149.1 TAP controller state machine with one-hot
// decodes of the current state, all combinational from the state register.
//
// state             | meaning
// ------------------+---------------------------------------------------
// TEST_LOGIC_RESET  | test logic idle, instruction forced to reset value
// RUN_TEST_IDLE     | idle between scans
// SELECT_DR / _IR   | branch point into DR or IR column
// CAPTURE_DR / _IR  | parallel load of the selected shift register
// SHIFT_DR / _IR    | serial shift, TDO driven
// EXIT1/2_DR / _IR  | leave shift, to pause or update
// PAUSE_DR / _IR    | hold shift register contents
// UPDATE_DR / _IR   | commit; UPDATE_IR latches the new instruction
module adbg_tap_fsm
    import adbg_tap_pkg::*;
(
    input  logic tck,
    input  logic rst_n,
    input  logic tms,
    output logic test_logic_reset,
    output logic run_test_idle,
    output logic capture_dr,
    output logic shift_dr,
    output logic pause_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic enter_reset
);

    tap_state_e state;
    tap_state_e state_next;

    // State register, advanced on every rising TCK edge.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_TEST_LOGIC_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Standard TMS transition table.
    always_comb begin
        state_next = ST_TEST_LOGIC_RESET;
        case (state)
            ST_TEST_LOGIC_RESET: state_next = tms ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
            ST_RUN_TEST_IDLE:    state_next = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            ST_SELECT_DR:        state_next = tms ? ST_SELECT_IR        : ST_CAPTURE_DR;
            ST_CAPTURE_DR:       state_next = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
            ST_SHIFT_DR:         state_next = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
            ST_EXIT1_DR:         state_next = tms ? ST_UPDATE_DR        : ST_PAUSE_DR;
            ST_PAUSE_DR:         state_next = tms ? ST_EXIT2_DR         : ST_PAUSE_DR;
            ST_EXIT2_DR:         state_next = tms ? ST_UPDATE_DR        : ST_SHIFT_DR;
            ST_UPDATE_DR:        state_next = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            ST_SELECT_IR:        state_next = tms ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
            ST_CAPTURE_IR:       state_next = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
            ST_SHIFT_IR:         state_next = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
            ST_EXIT1_IR:         state_next = tms ? ST_UPDATE_IR        : ST_PAUSE_IR;
            ST_PAUSE_IR:         state_next = tms ? ST_EXIT2_IR         : ST_PAUSE_IR;
            ST_EXIT2_IR:         state_next = tms ? ST_UPDATE_IR        : ST_SHIFT_IR;
            ST_UPDATE_IR:        state_next = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            default:             state_next = ST_TEST_LOGIC_RESET;
        endcase
    end

    // One-hot decodes; enter_reset looks ahead so the instruction reloads
    // on the same edge that lands in Test-Logic-Reset.
    always_comb begin
        test_logic_reset = (state == ST_TEST_LOGIC_RESET);
        run_test_idle    = (state == ST_RUN_TEST_IDLE);
        capture_dr       = (state == ST_CAPTURE_DR);
        shift_dr         = (state == ST_SHIFT_DR);
        pause_dr         = (state == ST_PAUSE_DR);
        update_dr        = (state == ST_UPDATE_DR);
        capture_ir       = (state == ST_CAPTURE_IR);
        shift_ir         = (state == ST_SHIFT_IR);
        update_ir        = (state == ST_UPDATE_IR);
        enter_reset      = (state_next == ST_TEST_LOGIC_RESET);
    end

endmodule

// File: rtl/adbg_tap.sv
// adbg_tap: JTAG TAP for the debug module. Holds the IR, bypass and
// optional IDCODE registers and the negedge TDO flop; sequencing lives in
// adbg_tap_fsm.
// Optional feature macro: ADBG_TAP_IDCODE_EN (32-bit IDCODE register and
// opcode; without it 4'b0010 behaves as BYPASS and reset selects BYPASS).
module adbg_tap
    import adbg_tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
    parameter int unsigned IR_LENGTH    = 4
) (
    input  logic tck_i,
    input  logic rst_ni,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic tdi_o,
    output logic test_logic_reset_o,
    output logic run_test_idle_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic debug_select_o
);

`ifdef ADBG_TAP_IDCODE_EN
    localparam logic [IR_LENGTH-1:0] IR_RESET = IR_LENGTH'(OP_IDCODE);
`else
    localparam logic [IR_LENGTH-1:0] IR_RESET = IR_LENGTH'(OP_BYPASS);
`endif
    localparam logic [IR_LENGTH-1:0] IR_CAPTURE_VAL = IR_LENGTH'(IR_CAPTURE);

    logic capture_dr;
    logic shift_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic enter_reset;

    logic [IR_LENGTH-1:0] ir_sr;
    logic [IR_LENGTH-1:0] ir_latched;
    logic                 bypass_reg;
    logic                 idcode_tdo;
    logic                 dr_tdo;
    logic                 tdo_next;
    dr_sel_e              dr_sel;

    adbg_tap_fsm u_fsm (
        .tck              (tck_i),
        .rst_n            (rst_ni),
        .tms              (tms_i),
        .test_logic_reset (test_logic_reset_o),
        .run_test_idle    (run_test_idle_o),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .pause_dr         (pause_dr_o),
        .update_dr        (update_dr_o),
        .capture_ir       (capture_ir),
        .shift_ir         (shift_ir),
        .update_ir        (update_ir),
        .enter_reset      (enter_reset)
    );

    assign shift_dr_o     = shift_dr;
    assign capture_dr_o   = capture_dr;
    assign tdo_oe_o       = shift_dr | shift_ir;
    assign tdi_o          = tdi_i;
    assign dr_sel         = decode_dr(4'(ir_latched));
    assign debug_select_o = (dr_sel == DR_DEBUG);

    // IR shift register: fixed capture pattern, shifts in at MSB.
    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_sr <= IR_CAPTURE_VAL;
        end else if (capture_ir) begin
            ir_sr <= IR_CAPTURE_VAL;
        end else if (shift_ir) begin
            ir_sr <= {tdi_i, ir_sr[IR_LENGTH-1:1]};
        end
    end

    // Latched instruction: committed when leaving Update-IR, restored on
    // any TMS-driven entry to Test-Logic-Reset.
    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_latched <= IR_RESET;
        end else if (enter_reset) begin
            ir_latched <= IR_RESET;
        end else if (update_ir) begin
            ir_latched <= ir_sr;
        end
    end

    // Bypass register: cleared on capture, one-bit delay while shifting.
    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bypass_reg <= 1'b0;
        end else if (dr_sel == DR_BYPASS) begin
            if (capture_dr) begin
                bypass_reg <= 1'b0;
            end else if (shift_dr) begin
                bypass_reg <= tdi_i;
            end
        end
    end

`ifdef ADBG_TAP_IDCODE_EN
    localparam logic [31:0] IDCODE_SEED = {IDCODE_VALUE[31:1], 1'b1};

    logic [31:0] idcode_sr;

    // IDCODE register: loaded on capture, shifted out LSB first.
    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idcode_sr <= IDCODE_SEED;
        end else if (dr_sel == DR_IDCODE) begin
            if (capture_dr) begin
                idcode_sr <= IDCODE_SEED;
            end else if (shift_dr) begin
                idcode_sr <= {tdi_i, idcode_sr[31:1]};
            end
        end
    end

    assign idcode_tdo = idcode_sr[0];
`else
    logic unused_idcode;

    assign idcode_tdo    = 1'b0;
    assign unused_idcode = ^IDCODE_VALUE;
`endif

    // Serial output of the data register picked by the instruction.
    always_comb begin
        dr_tdo = bypass_reg;
        case (dr_sel)
            DR_DEBUG:  dr_tdo = debug_tdo_i;
            DR_IDCODE: dr_tdo = idcode_tdo;
            default:   dr_tdo = bypass_reg;
        endcase
    end

    // TDO source depends on which column is shifting; quiet otherwise.
    always_comb begin
        tdo_next = 1'b0;
        if (shift_ir) begin
            tdo_next = ir_sr[0];
        end else if (shift_dr) begin
            tdo_next = dr_tdo;
        end
    end

    // TDO retimed to the falling edge so it is stable at the next rise.
    always_ff @(negedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tdo_o <= 1'b0;
        end else begin
            tdo_o <= tdo_next;
        end
    end

endmodule

// File: tb/tb_adbg_tap.sv
// Directed testbench for adbg_tap; expectations follow the build macro
// ADBG_TAP_IDCODE_EN.
module tb_adbg_tap;

    logic tck = 1'b0;
    logic rst_n;
    logic tms;
    logic tdi;
    logic debug_tdo;
    logic tdo;
    logic tdo_oe;
    logic tdi_out;
    logic tlr, rti, sdr, pdr, udr, cdr;
    logic debug_select;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IDCODE = 32'h149511C3;

    adbg_tap dut (
        .tck_i              (tck),
        .rst_ni             (rst_n),
        .tms_i              (tms),
        .tdi_i              (tdi),
        .tdo_o              (tdo),
        .tdo_oe_o           (tdo_oe),
        .debug_tdo_i        (debug_tdo),
        .tdi_o              (tdi_out),
        .test_logic_reset_o (tlr),
        .run_test_idle_o    (rti),
        .shift_dr_o         (sdr),
        .pause_dr_o         (pdr),
        .update_dr_o        (udr),
        .capture_dr_o       (cdr),
        .debug_select_o     (debug_select)
    );

    always #10 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One TCK cycle; returns 1 ns after the falling edge so both the state
    // and TDO have settled.
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    function automatic logic [5:0] decodes();
        return {tlr, rti, sdr, pdr, udr, cdr};
    endfunction

    // From Run-Test/Idle: load an opcode, return the four captured IR bits
    // in shift order (bit 0 first), end in Run-Test/Idle.
    task automatic load_ir(input logic [3:0] op, output logic [3:0] out);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        check("ir_shift_oe", {30'd0, tdo_oe, sdr}, 32'h2);
        out[0] = tdo;
        step(0, op[0]); out[1] = tdo;
        step(0, op[1]); out[2] = tdo;
        step(0, op[2]); out[3] = tdo;
        step(1, op[3]);
        step(1, 0);
        step(0, 0);
    endtask

    // From Run-Test/Idle into Shift-DR.
    task automatic enter_shift_dr();
        step(1, 0);
        step(0, 0);
        step(0, 0);
    endtask

    // From Shift-DR back to Run-Test/Idle through Update-DR.
    task automatic leave_shift_dr();
        step(1, 0);
        step(1, 0);
        step(0, 0);
    endtask

    initial begin
        logic [31:0] got32;
        logic [31:0] pat;
        logic [31:0] exp32;
        logic [3:0]  irout;
        logic [4:0]  bits5;
        logic [1:0]  bits2;

        rst_n     = 1'b0;
        tms       = 1'b1;
        tdi       = 1'b0;
        debug_tdo = 1'b0;
        #25;
        check("reset_decodes", {26'd0, decodes()}, {26'd0, 6'b100000});
        check("reset_outs", {29'd0, debug_select, tdo, tdo_oe}, 32'h0);
        @(negedge tck);
        #1;
        rst_n = 1'b1;

        step(0, 0);
        check("rti_decodes", {26'd0, decodes()}, {26'd0, 6'b010000});

        // Default data register after reset.
        step(1, 0);
        step(0, 0);
        check("capture_dr_decodes", {26'd0, decodes()}, {26'd0, 6'b000001});
        step(0, 0);
        check("shift_dr_decodes", {26'd0, decodes()}, {26'd0, 6'b001000});
        check("shift_dr_oe", {31'd0, tdo_oe}, 32'h1);
        pat = 32'hA5C30F69;
        got32[0] = tdo;
        for (int i = 1; i < 32; i++) begin
            step(0, pat[i-1]);
            got32[i] = tdo;
        end
`ifdef ADBG_TAP_IDCODE_EN
        exp32 = IDCODE;
`else
        exp32 = {pat[30:0], 1'b0};
`endif
        check("reset_dr_scan", got32, exp32);
        step(1, 0);
        step(1, 0);
        check("update_dr_decodes", {26'd0, decodes()}, {26'd0, 6'b000010});
        step(0, 0);

        // DEBUG instruction routes debug_tdo_i.
        load_ir(4'b1000, irout);
        check("ir_capture_out", {28'd0, irout}, 32'h5);
        check("debug_select_on", {31'd0, debug_select}, 32'h1);
        step(1, 0);
        step(0, 0);
        debug_tdo = 1'b1;
        step(0, 0);
        check("debug_tdo_1", {31'd0, tdo}, 32'h1);
        debug_tdo = 1'b0;
        step(0, 1);
        check("debug_tdo_0", {31'd0, tdo}, 32'h0);
        debug_tdo = 1'b1;
        step(0, 0);
        check("debug_tdo_1b", {31'd0, tdo}, 32'h1);
        debug_tdo = 1'b0;
        tdi = 1'b1;
        #1;
        check("tdi_pass_1", {31'd0, tdi_out}, 32'h1);
        tdi = 1'b0;
        #1;
        check("tdi_pass_0", {31'd0, tdi_out}, 32'h0);

        // Five TMS=1 cycles from Shift-DR.
        for (int i = 0; i < 5; i++) step(1, 0);
        check("tms_reset_decodes", {26'd0, decodes()}, {26'd0, 6'b100000});
        check("tms_reset_debug_sel", {31'd0, debug_select}, 32'h0);
        step(0, 0);
        enter_shift_dr();
        bits2[0] = tdo;
        step(0, 0);
        bits2[1] = tdo;
`ifdef ADBG_TAP_IDCODE_EN
        check("tms_reset_instr", {30'd0, bits2}, {30'd0, IDCODE[1:0]});
`else
        check("tms_reset_instr", {30'd0, bits2}, 32'h0);
`endif
        leave_shift_dr();

        // BYPASS: one-cycle delay.
        load_ir(4'b1111, irout);
        check("ir_capture_out_byp", {28'd0, irout}, 32'h5);
        check("bypass_debug_sel", {31'd0, debug_select}, 32'h0);
        enter_shift_dr();
        bits5[0] = tdo;
        step(0, 1); bits5[1] = tdo;
        step(0, 0); bits5[2] = tdo;
        step(0, 1); bits5[3] = tdo;
        step(0, 1); bits5[4] = tdo;
        check("bypass_stream", {27'd0, bits5}, {27'd0, 5'b11010});
        leave_shift_dr();

        // Opcode 0010.
        load_ir(4'b0010, irout);
        enter_shift_dr();
        bits2[0] = tdo;
        step(0, 1);
        bits2[1] = tdo;
`ifdef ADBG_TAP_IDCODE_EN
        check("op_0010", {30'd0, bits2}, {30'd0, IDCODE[1:0]});
`else
        check("op_0010", {30'd0, bits2}, 32'h2);
`endif
        leave_shift_dr();

        // Undefined opcode behaves as BYPASS.
        load_ir(4'b0111, irout);
        enter_shift_dr();
        bits2[0] = tdo;
        step(0, 1);
        bits2[1] = tdo;
        check("op_undef_bypass", {30'd0, bits2}, 32'h2);
        leave_shift_dr();

        // Pause-DR, then five TMS=1 cycles to reset.
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        check("pause_dr_decodes", {26'd0, decodes()}, {26'd0, 6'b000100});
        for (int i = 0; i < 5; i++) step(1, 0);
        check("pause_to_reset", {26'd0, decodes()}, {26'd0, 6'b100000});

        // Pause-IR to reset.
        step(0, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        check("pause_ir_to_reset", {26'd0, decodes()}, {26'd0, 6'b100000});

        // Reset mid-IR-shift discards the partial instruction.
        step(0, 0);
        load_ir(4'b1000, irout);
        check("debug_select_again", {31'd0, debug_select}, 32'h1);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midshift_rst_decodes", {26'd0, decodes()}, {26'd0, 6'b100000});
        check("midshift_rst_outs", {29'd0, debug_select, tdo, tdo_oe}, 32'h0);
        @(negedge tck);
        #1;
        rst_n = 1'b1;
        step(0, 0);
        check("midshift_no_update", {26'd0, decodes()}, {26'd0, 6'b010000});
        check("midshift_debug_sel", {31'd0, debug_select}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule
